// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// fetch stage (IF) and the memory stage (DM).
//
// Handshake: each requester raises req with stable address/data and holds it
// until its ack; ack is a one-cycle pulse and rdata is valid while ack is high.
// A requester is ignored in its own ack cycle, so holding req through the ack
// never produces a second grant.
//
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking;
// otherwise DM has fixed priority over IF.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              stall_if,
    output logic              stall_dm,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       own;
    logic       if_elig;
    logic       dm_elig;
    logic       grant;
    logic       grant_dm;
    logic       done;

`ifdef MEM_ARB_RR_EN
    // Owner that won the most recent tie; only ties update it.
    logic       last_own;
`endif

    // A requester being acked this cycle is not eligible again.
    assign if_elig   = if_req & ~if_ack;
    assign dm_elig   = dm_req & ~dm_ack;
    assign stall_if  = if_req & ~if_ack;
    assign stall_dm  = dm_req & ~dm_ack;
    assign dbg_state = state;

    // Next-state, grant decision and access completion.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_dm  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (if_elig | dm_elig) begin
                    grant     = 1'b1;
`ifdef MEM_ARB_RR_EN
                    grant_dm  = dm_elig & (~if_elig | ~last_own);
`else
                    grant_dm  = dm_elig;
`endif
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory port registers, wait counter, acks and read data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= 4'd0;
            own       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= 2'b00;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            dm_ack    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_own  <= 1'b1;
`endif
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            if (grant) begin
                own       <= grant_dm;
                mem_addr  <= grant_dm ? dm_addr : if_addr;
                mem_we    <= grant_dm & dm_we;
                mem_size  <= grant_dm ? dm_size : 2'b00;
                mem_wdata <= grant_dm ? dm_wdata : '0;
                mem_en    <= 1'b1;
                cnt       <= WAIT_INIT;
`ifdef MEM_ARB_RR_EN
                if (if_elig & dm_elig) begin
                    last_own <= grant_dm;
                end
`endif
            end else if (done) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (own) begin
                    dm_ack <= 1'b1;
                    if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                    end
                end else begin
                    if_ack   <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end else if (state == ACCESS) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (WAIT_CYCLES 0 and 3) driven by
// scenario tasks; expected timing and data come from the transaction rules
// (grant next cycle, W+1 access cycles, ack at W+2) and a bench-owned memory.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_a       [2];
    logic        if_req_a    [2];
    logic        if_ack_a    [2];
    logic        dm_req_a    [2];
    logic        dm_we_a     [2];
    logic        dm_ack_a    [2];
    logic        stall_if_a  [2];
    logic        stall_dm_a  [2];
    logic        mem_en_a    [2];
    logic        mem_we_a    [2];
    logic        dbg_state_a [2];
    logic [1:0]  dm_size_a   [2];
    logic [1:0]  mem_size_a  [2];
    logic [31:0] if_addr_a   [2];
    logic [31:0] if_rdata_a  [2];
    logic [31:0] dm_addr_a   [2];
    logic [31:0] dm_wdata_a  [2];
    logic [31:0] dm_rdata_a  [2];
    logic [31:0] mem_addr_a  [2];
    logic [31:0] mem_wdata_a [2];
    logic [31:0] mem_rdata_a [2];

    logic [31:0] mem_arr [2][256];

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] exp_if_rd [2];
    logic [31:0] exp_dm_rd [2];
    logic        ref_last  [2];
    int          wait_of   [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign mem_rdata_a[g] = mem_arr[g][mem_addr_a[g][9:2]];
        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(g * 3)) u_dut (
            .clk       (clk),
            .rst       (rst_a[g]),
            .if_req    (if_req_a[g]),
            .if_addr   (if_addr_a[g]),
            .if_rdata  (if_rdata_a[g]),
            .if_ack    (if_ack_a[g]),
            .dm_req    (dm_req_a[g]),
            .dm_we     (dm_we_a[g]),
            .dm_size   (dm_size_a[g]),
            .dm_addr   (dm_addr_a[g]),
            .dm_wdata  (dm_wdata_a[g]),
            .dm_rdata  (dm_rdata_a[g]),
            .dm_ack    (dm_ack_a[g]),
            .stall_if  (stall_if_a[g]),
            .stall_dm  (stall_dm_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_size  (mem_size_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata_a[g]),
            .dbg_state (dbg_state_a[g])
        );
    end

    function automatic logic [136:0] all_outs(input int k);
        return {if_rdata_a[k], if_ack_a[k], dm_rdata_a[k], dm_ack_a[k],
                stall_if_a[k], stall_dm_a[k], mem_en_a[k], mem_we_a[k],
                mem_size_a[k], mem_addr_a[k], mem_wdata_a[k], dbg_state_a[k]};
    endfunction

    // Hold reset for two cycles, check every output at its reset value.
    task automatic test_reset(input int k);
        @(negedge clk);
        rst_a[k] = 1'b0;
        if_req_a[k] = 1'b0; if_addr_a[k] = '0;
        dm_req_a[k] = 1'b0; dm_we_a[k] = 1'b0; dm_size_a[k] = 2'b00;
        dm_addr_a[k] = '0; dm_wdata_a[k] = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (all_outs(k) !== 137'd0) $display("FAIL reset_outs[%0d] got %h want 0", k, all_outs(k));
        else n_pass++;
        rst_a[k] = 1'b1;
        exp_if_rd[k] = '0; exp_dm_rd[k] = '0; ref_last[k] = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({mem_en_a[k], if_ack_a[k], dm_ack_a[k]} !== 3'b000)
            $display("FAIL idle_after_reset[%0d] got %b want 000", k, {mem_en_a[k], if_ack_a[k], dm_ack_a[k]});
        else n_pass++;
    endtask

    // One transaction from IDLE; req is held through its ack cycle and then
    // dropped, unless drop_early drops it inside the access.
    task automatic do_single(input int k, input bit is_dm, input bit we, input logic [1:0] sz,
                             input logic [31:0] addr, input logic [31:0] wd, input bit drop_early);
        int          w;
        bit          req_now;
        bit          en;
        bit          ack;
        logic [6:0]  exp_ctl;
        logic [6:0]  act_ctl;
        w = wait_of[k];
        req_now = 1'b0;
        @(negedge clk);
        for (int c = 0; c <= w + 3; c++) begin
            if (c == 0) begin
                if (is_dm) begin
                    dm_req_a[k] = 1'b1; dm_we_a[k] = we; dm_size_a[k] = sz;
                    dm_addr_a[k] = addr; dm_wdata_a[k] = wd;
                end else begin
                    if_req_a[k] = 1'b1; if_addr_a[k] = addr;
                end
                req_now = 1'b1;
                if (!is_dm || !we) exp_q.push_back(mem_arr[k][addr[9:2]]);
            end else begin
                @(negedge clk);
            end
            if ((drop_early && c == 2) || c == w + 3) begin
                if (is_dm) dm_req_a[k] = 1'b0; else if_req_a[k] = 1'b0;
                req_now = 1'b0;
            end
            #1;
            en  = (c >= 1) && (c <= w + 1);
            ack = (c == w + 2);
            if (ack && (!is_dm || !we)) begin
                if (is_dm) exp_dm_rd[k] = exp_q.pop_front();
                else       exp_if_rd[k] = exp_q.pop_front();
            end
            exp_ctl = {en, en & is_dm & we, ack & !is_dm, ack & is_dm,
                       req_now & !is_dm & !ack, req_now & is_dm & !ack, en};
            act_ctl = {mem_en_a[k], mem_we_a[k], if_ack_a[k], dm_ack_a[k],
                       stall_if_a[k], stall_dm_a[k], dbg_state_a[k]};
            n_checks++;
            if (act_ctl !== exp_ctl) $display("FAIL ctl[%0d] cyc %0d got %b want %b", k, c, act_ctl, exp_ctl);
            else n_pass++;
            if (en) begin
                n_checks++;
                if ({mem_addr_a[k], mem_size_a[k]} !== {addr, (is_dm ? sz : 2'b00)})
                    $display("FAIL mem_addr_size[%0d] cyc %0d got %h/%b want %h/%b", k, c,
                             mem_addr_a[k], mem_size_a[k], addr, (is_dm ? sz : 2'b00));
                else n_pass++;
                if (is_dm && we) begin
                    n_checks++;
                    if (mem_wdata_a[k] !== wd) $display("FAIL mem_wdata[%0d] got %h want %h", k, mem_wdata_a[k], wd);
                    else n_pass++;
                end
            end
            n_checks++;
            if ({if_rdata_a[k], dm_rdata_a[k]} !== {exp_if_rd[k], exp_dm_rd[k]})
                $display("FAIL rdata[%0d] cyc %0d got %h/%h want %h/%h", k, c,
                         if_rdata_a[k], dm_rdata_a[k], exp_if_rd[k], exp_dm_rd[k]);
            else n_pass++;
        end
    endtask

    // Fetch of 0x10 returning 0x00500093 with no wait states.
    task automatic test_if_fetch();
        do_single(0, 1'b0, 1'b0, 2'b00, 32'h10, 32'h0, 1'b0);
    endtask

    // Word store of 0xDEADBEEF to 0x200 with three wait states.
    task automatic test_dm_store();
        do_single(1, 1'b1, 1'b1, 2'b00, 32'h200, 32'hDEADBEEF, 1'b0);
    endtask

    // Both requesters raise req in the same cycle.
    task automatic test_tie(input int k, input bit dwe);
        int          w;
        int          t_if;
        int          t_dm;
        bit          dm_first;
        bit          if_now;
        bit          dm_now;
        bit          win1;
        bit          win2;
        bit          en;
        bit          own_dm;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic [6:0]  exp_ctl;
        logic [6:0]  act_ctl;
        w  = wait_of[k];
        ia = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        da = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        wd = $urandom;
        sz = 2'($urandom_range(0, 2));
`ifdef MEM_ARB_RR_EN
        dm_first = !ref_last[k];
`else
        dm_first = 1'b1;
`endif
        t_dm = dm_first ? w + 2 : 2 * w + 4;
        t_if = dm_first ? 2 * w + 4 : w + 2;
        @(negedge clk);
        if_req_a[k] = 1'b1; if_addr_a[k] = ia;
        dm_req_a[k] = 1'b1; dm_we_a[k] = dwe; dm_size_a[k] = sz;
        dm_addr_a[k] = da; dm_wdata_a[k] = wd;
        if_now = 1'b1; dm_now = 1'b1;
        for (int c = 0; c <= 2 * w + 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == t_if + 1) begin if_req_a[k] = 1'b0; if_now = 1'b0; end
            if (c == t_dm + 1) begin dm_req_a[k] = 1'b0; dm_now = 1'b0; end
            #1;
            win1   = (c >= 1) && (c <= w + 1);
            win2   = (c >= w + 3) && (c <= 2 * w + 3);
            en     = win1 | win2;
            own_dm = win1 ? dm_first : !dm_first;
            if (c == t_if) exp_if_rd[k] = mem_arr[k][ia[9:2]];
            if (c == t_dm && !dwe) exp_dm_rd[k] = mem_arr[k][da[9:2]];
            exp_ctl = {en, en & own_dm & dwe, c == t_if, c == t_dm,
                       if_now & (c != t_if), dm_now & (c != t_dm), en};
            act_ctl = {mem_en_a[k], mem_we_a[k], if_ack_a[k], dm_ack_a[k],
                       stall_if_a[k], stall_dm_a[k], dbg_state_a[k]};
            n_checks++;
            if (act_ctl !== exp_ctl) $display("FAIL tie_ctl[%0d] cyc %0d got %b want %b", k, c, act_ctl, exp_ctl);
            else n_pass++;
            if (en) begin
                n_checks++;
                if ({mem_addr_a[k], mem_size_a[k]} !== {(own_dm ? da : ia), (own_dm ? sz : 2'b00)})
                    $display("FAIL tie_addr[%0d] cyc %0d got %h/%b want %h/%b", k, c, mem_addr_a[k],
                             mem_size_a[k], (own_dm ? da : ia), (own_dm ? sz : 2'b00));
                else n_pass++;
            end
            n_checks++;
            if ({if_rdata_a[k], dm_rdata_a[k]} !== {exp_if_rd[k], exp_dm_rd[k]})
                $display("FAIL tie_rdata[%0d] cyc %0d got %h/%h want %h/%h", k, c,
                         if_rdata_a[k], dm_rdata_a[k], exp_if_rd[k], exp_dm_rd[k]);
            else n_pass++;
        end
        ref_last[k] = dm_first;
    endtask

    // Reset in cycle 2 of a three-wait-state load aborts it without an ack.
    task automatic test_reset_mid();
        logic [31:0] a;
        bit          seen_bad;
        a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        @(negedge clk);
        dm_req_a[1] = 1'b1; dm_we_a[1] = 1'b0; dm_size_a[1] = 2'b00; dm_addr_a[1] = a;
        @(negedge clk);
        #1;
        n_checks++;
        if (mem_en_a[1] !== 1'b1) $display("FAIL mid_grant got %b want 1", mem_en_a[1]);
        else n_pass++;
        @(negedge clk);
        rst_a[1] = 1'b0; dm_req_a[1] = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (all_outs(1) !== 137'd0) $display("FAIL mid_reset_outs got %h want 0", all_outs(1));
        else n_pass++;
        rst_a[1] = 1'b1;
        exp_if_rd[1] = '0; exp_dm_rd[1] = '0; ref_last[1] = 1'b1;
        seen_bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (dm_ack_a[1] !== 1'b0 || mem_en_a[1] !== 1'b0) seen_bad = 1'b1;
        end
        n_checks++;
        if (seen_bad) $display("FAIL mid_no_ack got activity want none");
        else n_pass++;
        do_single(1, 1'b1, 1'b0, 2'b00, a, 32'h0, 1'b0);
    endtask

    // Request dropped during the access still completes with an ack.
    task automatic test_drop_early();
        do_single(1, 1'b1, 1'b0, 2'b01, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, 1'b1);
        do_single(1, 1'b0, 1'b0, 2'b00, {22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, 1'b1);
    endtask

    // Random mix of fetches, loads and stores on both instances.
    task automatic test_random(input int k, input int n);
        bit is_dm;
        for (int i = 0; i < n; i++) begin
            is_dm = 1'($urandom_range(0, 1));
            do_single(k, is_dm, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                      {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom, 1'b0);
        end
    endtask

    initial begin
        wait_of[0] = 0;
        wait_of[1] = 3;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 256; i++) mem_arr[k][i] = $urandom;
        end
        mem_arr[0][4] = 32'h00500093;
        for (int k = 0; k < 2; k++) begin
            rst_a[k] = 1'b0; if_req_a[k] = 1'b0; dm_req_a[k] = 1'b0;
        end
        test_reset(0);
        test_reset(1);
        test_tie(0, 1'b0);
        test_tie(0, 1'b0);
        test_if_fetch();
        test_dm_store();
        test_random(1, 4);
        test_tie(1, 1'b1);
        test_tie(1, 1'b0);
        test_reset_mid();
        test_drop_early();
        test_random(0, 20);
        test_random(1, 20);
        test_tie(0, 1'b1);
        test_tie(1, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
